// File: rtl/sound_arbiter.sv
// Sound-effect arbiter: mixes background music with three prioritised ROM effects
// (lvl > hit > miss) sequenced on a tick timebase, with optional pre-emption and inter-note gaps.
module sound_arbiter #(
  parameter int GAP_TICKS = 1,
  parameter int PREEMPT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] bgm_note,
  input  logic       mute,
  input  logic       miss_req,
  input  logic       hit_req,
  input  logic       lvl_req,
  output logic [3:0] note,
  output logic       sfx_busy,
  output logic [1:0] sfx_id,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [2:0] pend_q, pend_d, clr;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] step_q, step_d;
  logic [1:0] gap_q, gap_d;
  logic [1:0] id_q, id_d;
  logic [3:0] note_q, note_d;
  logic [1:0] top_id;
  logic       start;
  logic       preempt_go;

  // Effect ROM; ids double as priority (1 miss, 2 hit, 3 lvl).
  function automatic logic [3:0] rom_note(input logic [1:0] id, input logic [1:0] step);
    case (id)
      2'd1:    rom_note = (step == 2'd0) ? 4'd5 : 4'd2;
      2'd2:    rom_note = (step == 2'd0) ? 4'd12 : 4'd14;
      2'd3: begin
        case (step)
          2'd0:    rom_note = 4'd7;
          2'd1:    rom_note = 4'd9;
          2'd2:    rom_note = 4'd10;
          default: rom_note = 4'd12;
        endcase
      end
      default: rom_note = 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] rom_len(input logic [1:0] id);
    case (id)
      2'd1:    rom_len = 2'd3;
      2'd2,
      2'd3:    rom_len = 2'd2;
      default: rom_len = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] id);
    case (id)
      2'd3:    last_step = 2'd3;
      2'd1,
      2'd2:    last_step = 2'd1;
      default: last_step = 2'd0;
    endcase
  endfunction

  always_comb begin
    top_id = pend_q[2] ? 2'd3 : pend_q[1] ? 2'd2 : pend_q[0] ? 2'd1 : 2'd0;
  end

  assign preempt_go = (PREEMPT != 0) && (top_id > id_q);

  // State register; a request pulse in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 3'b000;
      cnt_q   <= 2'd0;
      step_q  <= 2'd0;
      gap_q   <= 2'd0;
      id_q    <= 2'd0;
      note_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      id_q    <= id_d;
      note_q  <= note_d;
    end
  end

  // Next-state logic; every transition is gated by tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    gap_d   = gap_q;
    id_d    = id_q;
    start   = 1'b0;
    clr     = 3'b000;
    if (tick) begin
      case (state_q)
        IDLE: start = (top_id != 2'd0);
        PLAY: begin
          if (preempt_go) begin
            start = 1'b1;
          end else if (cnt_q <= 2'd1) begin
            cnt_d = 2'd0;
            if (GAP_TICKS > 0) begin
              state_d = GAP;
              gap_d   = 2'(GAP_TICKS);
            end else if (step_q == last_step(id_q)) begin
              state_d = IDLE;
              id_d    = 2'd0;
              step_d  = 2'd0;
            end else begin
              step_d = step_q + 2'd1;
              cnt_d  = rom_len(id_q);
            end
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        GAP: begin
          if (preempt_go) begin
            start = 1'b1;
          end else if (gap_q <= 2'd1) begin
            gap_d = 2'd0;
            if (step_q == last_step(id_q)) begin
              state_d = IDLE;
              id_d    = 2'd0;
              step_d  = 2'd0;
            end else begin
              state_d = PLAY;
              step_d  = step_q + 2'd1;
              cnt_d   = rom_len(id_q);
            end
          end else begin
            gap_d = gap_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (start) begin
        state_d = PLAY;
        id_d    = top_id;
        step_d  = 2'd0;
        cnt_d   = rom_len(top_id);
        gap_d   = 2'd0;
        clr     = 3'b001 << (top_id - 2'd1);
      end
    end
    pend_d = (pend_q & ~clr) | {lvl_req, hit_req, miss_req};
  end

  // Output logic: note is registered from the state being entered.
  always_comb begin
    if (mute)                note_d = 4'd0;
    else if (state_d == IDLE) note_d = bgm_note;
    else if (state_d == PLAY) note_d = rom_note(id_d, step_d);
    else                      note_d = 4'd0;
    note      = note_q;
    sfx_busy  = (state_q != IDLE);
    sfx_id    = id_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter: a driver pushes hand-computed expectations into a queue
// and a negedge monitor pops and compares them against one of two DUT configurations.
module tb_sound_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] bgm_note = 4'd7;
  logic       mute = 1'b0;
  logic       miss_req = 1'b0, hit_req = 1'b0, lvl_req = 1'b0;

  logic [3:0] a_note, b_note;
  logic       a_busy, b_busy;
  logic [1:0] a_id, b_id, a_st, b_st;

  logic [3:0] bgm_v  = 4'd7;
  logic       mute_v = 1'b0;

  // Entry: {check_en, dut_sel (0 = gap 1, 1 = gap 0), busy, id[1:0], note[3:0]}
  logic [8:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;

  sound_arbiter #(.GAP_TICKS(1), .PREEMPT(1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .bgm_note(bgm_note), .mute(mute),
    .miss_req(miss_req), .hit_req(hit_req), .lvl_req(lvl_req),
    .note(a_note), .sfx_busy(a_busy), .sfx_id(a_id), .dbg_state(a_st));

  sound_arbiter #(.GAP_TICKS(0), .PREEMPT(1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .bgm_note(bgm_note), .mute(mute),
    .miss_req(miss_req), .hit_req(hit_req), .lvl_req(lvl_req),
    .note(b_note), .sfx_busy(b_busy), .sfx_id(b_id), .dbg_state(b_st));

  always #5 clk = ~clk;

  function automatic logic [6:0] e(input logic b, input logic [1:0] id, input logic [3:0] n);
    return {b, id, n};
  endfunction

  // One clock of stimulus; the expectation describes outputs after the coming posedge.
  task automatic drive(input logic t, input logic [2:0] req, input logic r,
                       input logic chk, input logic sel, input logic [6:0] exp, input string nm);
    @(negedge clk);
    #1;
    tick     = t;
    {lvl_req, hit_req, miss_req} = req;
    rst      = r;
    bgm_note = bgm_v;
    mute     = mute_v;
    exp_q.push_back({chk, sel, exp});
    name_q.push_back(nm);
  endtask

  task automatic pulse(input logic [2:0] req);
    drive(1'b0, req, 1'b0, 1'b0, 1'b0, 7'd0, "");
  endtask

  // Tick every 4 clocks; compare right after the tick edge.
  task automatic tick_chk(input logic sel, input logic [6:0] exp, input string nm);
    repeat (3) drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 7'd0, "");
    drive(1'b1, 3'b000, 1'b0, 1'b1, sel, exp, nm);
  endtask

  // Notes packed left-aligned, one nibble per tick.
  task automatic play(input logic sel, input logic [1:0] id, input logic [63:0] ns,
                      input int n, input string nm);
    for (int i = 0; i < n; i++)
      tick_chk(sel, e(1'b1, id, ns[63-4*i -: 4]), $sformatf("%s_t%0d", nm, i + 1));
  endtask

  always @(negedge clk) begin
    logic [8:0] ent;
    logic [6:0] act;
    string      nm;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      nm  = name_q.pop_front();
      if (ent[8]) begin
        act = ent[7] ? {b_busy, b_id, b_note} : {a_busy, a_id, a_note};
        checks++;
        if (act !== ent[6:0]) begin
          failures++;
          $display("FAIL %s: got busy=%0d id=%0d note=%0d, want busy=%0d id=%0d note=%0d",
                   nm, act[6], act[5:4], act[3:0], ent[6], ent[5:4], ent[3:0]);
        end
      end
    end
  end

  initial begin
    // Reset, with requests during reset that must be dropped.
    drive(1'b0, 3'b010, 1'b1, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd0), "reset_a");
    drive(1'b0, 3'b111, 1'b1, 1'b1, 1'b1, e(1'b0, 2'd0, 4'd0), "reset_b");
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd7), "bgm_after_rst");
    drive(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd7), "idle_tick");
    mute_v = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd0), "mute");
    mute_v = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd7), "unmute");
    bgm_v = 4'd3;
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd3), "bgm_follow");
    bgm_v = 4'd7;
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd7), "bgm_back");

    // Hit effect with one-tick gaps.
    pulse(3'b010);
    play(1'b0, 2'd2, 64'hCC0EE00000000000, 6, "hit");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "hit_end");

    // Request on a tick is only served on the next tick; lvl then pre-empts miss.
    drive(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd7), "req_with_tick");
    tick_chk(1'b0, e(1'b1, 2'd1, 4'd5), "miss_start");
    pulse(3'b100);
    play(1'b0, 2'd3, 64'h770990AA0CC00000, 12, "preempt");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "preempt_end");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "miss_not_resumed");

    // Lower-priority requests queue behind lvl and are served in priority order.
    pulse(3'b100);
    tick_chk(1'b0, e(1'b1, 2'd3, 4'd7), "lvl_start");
    pulse(3'b011);
    play(1'b0, 2'd3, 64'h70990AA0CC000000, 11, "lvl");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "lvl_end");
    play(1'b0, 2'd2, 64'hCC0EE00000000000, 6, "hit2");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "hit2_end");
    play(1'b0, 2'd1, 64'h5550222000000000, 8, "miss");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "miss_end");

    // Reset in the middle of an effect, coincident with a new request.
    pulse(3'b010);
    tick_chk(1'b0, e(1'b1, 2'd2, 4'd12), "hit3_start");
    drive(1'b0, 3'b010, 1'b1, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd0), "rst_mid");
    drive(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, e(1'b0, 2'd0, 4'd7), "rst_release");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "after_rst_1");
    tick_chk(1'b0, e(1'b0, 2'd0, 4'd7), "after_rst_2");

    // Zero-gap configuration: lvl notes back to back.
    pulse(3'b100);
    play(1'b1, 2'd3, 64'h7799AACC00000000, 8, "gap0");
    tick_chk(1'b1, e(1'b0, 2'd0, 4'd7), "gap0_end");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
